// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one st/ready Divider among N_REQ requesters, with a divide-by-zero bypass and a watchdog
module divider_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int START_TO = 4,
  parameter int DONE_TO  = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] dividend_in,
  input  logic [N_REQ*WIDTH-1:0] divisor_in,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_quot,
  output logic [WIDTH-1:0]       rsp_rem,
  output logic                   rsp_dbz,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   div_st,
  output logic [WIDTH-1:0]       div_q,
  output logic [WIDTH-1:0]       div_m,
  input  logic                   div_ready,
  input  logic [WIDTH-1:0]       div_qout,
  input  logic [WIDTH-1:0]       div_aout
);
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, RESP} state_t;
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2((START_TO > DONE_TO ? START_TO : DONE_TO) + 1);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, pick, idx;
  logic found;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dq_q, dq_d, dm_q, dm_d, dvd, dvs;
  logic dbz_q, dbz_d, err_q, err_d, st_q, busy_q;
  logic [N_REQ-1:0] vld_q, vld_d;
  // Search starts just after the last winner, so every requester is reached within N_REQ grants
  always_comb begin
    found = 1'b0;
    pick = ptr_q;
    idx = ptr_q;
    dvd = '0;
    dvs = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        dvd = dividend_in[i*WIDTH +: WIDTH];
        dvs = divisor_in[i*WIDTH +: WIDTH];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    cnt_d = cnt_q + CW'(1);
    quot_d = quot_q;
    rem_d = rem_q;
    dq_d = dq_q;
    dm_d = dm_q;
    dbz_d = dbz_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (found && div_ready) begin
        win_d = pick;
        ptr_d = pick;
        dq_d = dvd;
        dm_d = dvs;
        state_d = (dvs == '0) ? RESP : START;
        if (dvs == '0) begin
          quot_d = '1;
          rem_d = dvd;
          dbz_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
        cnt_d = '0;
      end
      WAIT_BUSY: if (!div_ready) begin
        state_d = WAIT_DONE;
        cnt_d = '0;
      end else if (cnt_q == CW'(START_TO - 1)) begin
        state_d = RESP;
        err_d = 1'b1;
        quot_d = '0;
        rem_d = '0;
      end
      WAIT_DONE: if (div_ready) begin
        state_d = RESP;
        quot_d = div_qout;
        rem_d = div_aout;
      end else if (cnt_q == CW'(DONE_TO - 1)) begin
        state_d = RESP;
        err_d = 1'b1;
        quot_d = '0;
        rem_d = '0;
      end
      RESP: begin
        state_d = IDLE;
        dbz_d = 1'b0;
        err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    vld_d = (state_d == RESP) ? (N_REQ'(1) << win_d) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(N_REQ - 1);
      win_q <= '0;
      cnt_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      dq_q <= '0;
      dm_q <= '0;
      dbz_q <= 1'b0;
      err_q <= 1'b0;
      vld_q <= '0;
      st_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      dq_q <= dq_d;
      dm_q <= dm_d;
      dbz_q <= dbz_d;
      err_q <= err_d;
      vld_q <= vld_d;
      st_q <= (state_d == START);
      busy_q <= (state_d != IDLE);
    end
  end
  assign rsp_valid = vld_q;
  assign rsp_quot = quot_q;
  assign rsp_rem = rem_q;
  assign rsp_dbz = dbz_q;
  assign rsp_err = err_q;
  assign busy = busy_q;
  assign div_st = st_q;
  assign div_q = dq_q;
  assign div_m = dm_q;
endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed checks of divider_arbiter against a behavioural st/ready Divider
module tb_divider_arbiter;
  localparam int N = 4, W = 8, R = 3, DTO = 31;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] dividend_in = '0, divisor_in = '0;
  logic [N-1:0] rsp_valid;
  logic [W-1:0] rsp_quot, rsp_rem, div_q, div_m;
  logic rsp_dbz, rsp_err, busy, div_st, div_ready;
  logic [W-1:0] div_qout = '0, div_aout = '0;
  logic mdl_rdy = 1'b1, stuck = 1'b0, hold_low = 1'b0, busy_seen;
  int run_left = 0, vectors = 0, miscompares = 0, st_cnt = 0, rsp_cnt = 0, lat, snap;
  logic [W-1:0] eq [4] = '{8'h12, 8'h0E, 8'h06, 8'h0F};
  logic [W-1:0] er [4] = '{8'h03, 8'h02, 8'h14, 8'h0F};
  assign div_ready = mdl_rdy && !hold_low;
  always #5 clk = ~clk;
  divider_arbiter #(.N_REQ(N), .WIDTH(W), .START_TO(4), .DONE_TO(DTO)) dut (
    .clk(clk), .rst(rst), .req(req), .dividend_in(dividend_in), .divisor_in(divisor_in),
    .rsp_valid(rsp_valid), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz),
    .rsp_err(rsp_err), .busy(busy), .div_st(div_st), .div_q(div_q), .div_m(div_m),
    .div_ready(div_ready), .div_qout(div_qout), .div_aout(div_aout)
  );
  // Divider: ready drops on the start edge, returns R+1 edges later unless stuck
  always @(posedge clk) begin
    if (div_st && div_ready) begin
      mdl_rdy <= 1'b0;
      run_left <= R;
      div_qout <= div_q / div_m;
      div_aout <= div_q % div_m;
    end else if (!mdl_rdy && !stuck) begin
      if (run_left == 0) mdl_rdy <= 1'b1;
      else run_left <= run_left - 1;
    end
  end
  always @(negedge clk) begin
    if (div_st) st_cnt++;
    if (|rsp_valid) rsp_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend_in[i*W +: W] = a;
    divisor_in[i*W +: W] = b;
  endtask
  task automatic wait_rsp(input int max, output int l);
    l = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (|rsp_valid) begin
        l = i;
        break;
      end
    end
  endtask
  task automatic check_rsp(input string tag, input logic [31:0] v, input logic [31:0] q,
                           input logic [31:0] r, input logic [31:0] z, input logic [31:0] e);
    check({tag, ".valid"}, 32'(rsp_valid), v);
    check({tag, ".quot"}, 32'(rsp_quot), q);
    check({tag, ".rem"}, 32'(rsp_rem), r);
    check({tag, ".dbz"}, 32'(rsp_dbz), z);
    check({tag, ".err"}, 32'(rsp_err), e);
  endtask
  task automatic check_zero(input string tag);
    check_rsp(tag, 0, 0, 0, 0, 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".div_st"}, 32'(div_st), 0);
    check({tag, ".div_q"}, 32'(div_q), 0);
    check({tag, ".div_m"}, 32'(div_m), 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    // single divide on requester 0
    set_slot(0, 8'hDB, 8'h0C);
    @(negedge clk);
    req = 4'b0001;
    wait_rsp(100, lat);
    req = 4'b0000;
    check_rsp("single", 1, 'h12, 'h03, 0, 0);
    check("single.lat", 32'(lat), R + 4);
    check("single.st_cnt", 32'(st_cnt), 1);
    check("single.div_q", 32'(div_q), 'hDB);
    check("single.div_m", 32'(div_m), 'h0C);
    // two requesters after reset: 0 before 2
    pulse_reset();
    set_slot(2, 8'hBC, 8'h1C);
    req = 4'b0101;
    wait_rsp(100, lat);
    req[0] = 1'b0;
    check_rsp("pair0", 1, 'h12, 'h03, 0, 0);
    wait_rsp(100, lat);
    req[2] = 1'b0;
    check_rsp("pair2", 4, 'h06, 'h14, 0, 0);
    // all held high: order 0,1,2,3,0
    pulse_reset();
    set_slot(1, 8'h64, 8'h07);
    set_slot(3, 8'hFF, 8'h10);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_rsp(100, lat);
      if (n == 4) req = 4'b0000;
      check_rsp($sformatf("rr%0d", n), 32'(1 << (n % 4)), 32'(eq[n%4]), 32'(er[n%4]), 0, 0);
    end
    // divide by zero bypasses the Divider
    set_slot(1, 8'h55, 8'h00);
    @(negedge clk);
    snap = st_cnt;
    req = 4'b0010;
    wait_rsp(100, lat);
    req = 4'b0000;
    check_rsp("dbz", 2, 'hFF, 'h55, 1, 0);
    check("dbz.lat", 32'(lat), 1);
    @(negedge clk);
    check("dbz.st_cnt", 32'(st_cnt), 32'(snap));
    check("dbz.after_valid", 32'(rsp_valid), 0);
    check("dbz.after_flag", 32'(rsp_dbz), 0);
    check("dbz.hold_quot", 32'(rsp_quot), 'hFF);
    // Divider never returns: watchdog fires DONE_TO cycles into WAIT_DONE
    stuck = 1'b1;
    req = 4'b0001;
    wait_rsp(100, lat);
    req = 4'b0000;
    check_rsp("tmo", 1, 0, 0, 0, 1);
    check("tmo.lat", 32'(lat), DTO + 3);
    stuck = 1'b0;
    set_slot(0, 8'h64, 8'h0A);
    @(negedge clk);
    req = 4'b0001;
    wait_rsp(100, lat);
    req = 4'b0000;
    check_rsp("tmo_next", 1, 'h0A, 'h00, 0, 0);
    // reset in WAIT_DONE aborts silently and restores the pointer
    set_slot(0, 8'hDB, 8'h0C);
    @(negedge clk);
    req = 4'b0001;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    check_zero("abort");
    snap = rsp_cnt;
    repeat (10) @(negedge clk);
    check("abort.no_rsp", 32'(rsp_cnt), 32'(snap));
    req = 4'b0011;
    wait_rsp(100, lat);
    req[0] = 1'b0;
    check_rsp("abort.first", 1, 'h12, 'h03, 0, 0);
    wait_rsp(100, lat);
    req[1] = 1'b0;
    check_rsp("abort.second", 2, 'hFF, 'h55, 1, 0);
    // no grant while the Divider is not ready
    hold_low = 1'b1;
    req = 4'b1000;
    busy_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      busy_seen = busy_seen | busy | div_st;
    end
    check("notready.busy", 32'(busy_seen), 0);
    hold_low = 1'b0;
    @(negedge clk);
    check("notready.grant_busy", 32'(busy), 1);
    check("notready.grant_st", 32'(div_st), 1);
    wait_rsp(100, lat);
    req = 4'b0000;
    check_rsp("notready", 8, 'h0F, 'h0F, 0, 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
